// File: rtl/int_reservation_station_if.sv
// Issue, common-result-bus and dispatch signals of the integer reservation station.
// The master side is the issue stage / CDB / ALU; the slave side is the station.
interface int_reservation_station_if #(
  parameter int OP_WIDTH    = 6,
  parameter int RS_ID_WIDTH = 5
);
  logic                   issue_valid;
  logic                   issue_ready;
  logic [RS_ID_WIDTH-1:0] issue_rs_id;
  logic [OP_WIDTH-1:0]    issue_op;
  logic                   issue_a_valid;
  logic [31:0]            issue_a_value;
  logic [RS_ID_WIDTH-1:0] issue_a_rs_id;
  logic                   issue_b_valid;
  logic [31:0]            issue_b_value;
  logic [RS_ID_WIDTH-1:0] issue_b_rs_id;

  logic                   cdb_valid;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id;
  logic [31:0]            cdb_value;

  logic                   disp_valid;
  logic                   disp_ready;
  logic [OP_WIDTH-1:0]    disp_op;
  logic [31:0]            disp_a;
  logic [31:0]            disp_b;
  logic [RS_ID_WIDTH-1:0] disp_rs_id;

  modport master (
    output issue_valid, issue_op,
    output issue_a_valid, issue_a_value, issue_a_rs_id,
    output issue_b_valid, issue_b_value, issue_b_rs_id,
    output cdb_valid, cdb_rs_id, cdb_value,
    output disp_ready,
    input  issue_ready, issue_rs_id,
    input  disp_valid, disp_op, disp_a, disp_b, disp_rs_id
  );

  modport slave (
    input  issue_valid, issue_op,
    input  issue_a_valid, issue_a_value, issue_a_rs_id,
    input  issue_b_valid, issue_b_value, issue_b_rs_id,
    input  cdb_valid, cdb_rs_id, cdb_value,
    input  disp_ready,
    output issue_ready, issue_rs_id,
    output disp_valid, disp_op, disp_a, disp_b, disp_rs_id
  );
endinterface

// File: rtl/int_reservation_station.sv
// Integer-unit reservation station: captures operands from issue and the CDB,
// dispatches the oldest entry whose operands are both valid.
module int_reservation_station #(
  parameter int ENTRIES     = 4,
  parameter int OP_WIDTH    = 6,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_ID_BASE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  int_reservation_station_if.slave rs
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef logic [RS_ID_WIDTH-1:0] rs_id_t;
  typedef logic [IDX_W-1:0]       idx_t;

  typedef struct packed {
    logic                busy;
    logic [OP_WIDTH-1:0] op;
    logic                a_valid;
    logic [31:0]         a_value;
    rs_id_t              a_tag;
    logic                b_valid;
    logic [31:0]         b_value;
    rs_id_t              b_tag;
  } entry_t;

  entry_t             entry_q [ENTRIES];
  entry_t             entry_d [ENTRIES];
  // age_q[i][j] set means entry i was allocated before entry j
  logic [ENTRIES-1:0] age_q   [ENTRIES];
  logic [ENTRIES-1:0] age_d   [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] has_older;
  logic               free_found;
  idx_t               alloc_idx;
  logic               sel_found;
  idx_t               sel_idx;
  logic               issue_fire;
  logic               disp_fire;
  logic               a_fwd;
  logic               b_fwd;

  function automatic rs_id_t idx_to_id(input idx_t idx);
    return rs_id_t'(RS_ID_BASE) + rs_id_t'(idx);
  endfunction

  // Lowest-index free entry, from registered busy bits only.
  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_q[i].busy) begin
        free_found = 1'b1;
        alloc_idx  = idx_t'(i);
      end
    end
  end

  // Oldest ready entry: the one no other ready entry is older than.
  always_comb begin
    ready     = '0;
    has_older = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = entry_q[i].busy && entry_q[i].a_valid && entry_q[i].b_valid;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && age_q[j][i]) has_older[i] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && !has_older[i]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(i);
      end
    end
  end

  assign rs.issue_ready = free_found;
  assign rs.issue_rs_id = idx_to_id(alloc_idx);
  assign rs.disp_valid  = sel_found;
  assign rs.disp_rs_id  = idx_to_id(sel_idx);
  assign rs.disp_op     = sel_found ? entry_q[sel_idx].op      : '0;
  assign rs.disp_a      = sel_found ? entry_q[sel_idx].a_value : '0;
  assign rs.disp_b      = sel_found ? entry_q[sel_idx].b_value : '0;

  assign issue_fire = rs.issue_valid && free_found;
  assign disp_fire  = sel_found && rs.disp_ready;
  assign a_fwd      = rs.cdb_valid && (rs.cdb_rs_id == rs.issue_a_rs_id);
  assign b_fwd      = rs.cdb_valid && (rs.cdb_rs_id == rs.issue_b_rs_id);

  // NOTE: every variable gets its default before any conditional write, so no latch is inferred.
  always_comb begin
    entry_d = entry_q;
    age_d   = age_q;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) entry_d[i].busy = 1'b0;
    end else begin
      if (rs.cdb_valid) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (entry_q[i].busy && !entry_q[i].a_valid && entry_q[i].a_tag == rs.cdb_rs_id) begin
            entry_d[i].a_valid = 1'b1;
            entry_d[i].a_value = rs.cdb_value;
          end
          if (entry_q[i].busy && !entry_q[i].b_valid && entry_q[i].b_tag == rs.cdb_rs_id) begin
            entry_d[i].b_valid = 1'b1;
            entry_d[i].b_value = rs.cdb_value;
          end
        end
      end
      if (disp_fire) entry_d[sel_idx].busy = 1'b0;
      // The allocated entry is free, so it never collides with the snoop or dispatch above.
      if (issue_fire) begin
        entry_d[alloc_idx].busy    = 1'b1;
        entry_d[alloc_idx].op      = rs.issue_op;
        entry_d[alloc_idx].a_valid = rs.issue_a_valid || a_fwd;
        entry_d[alloc_idx].a_value = rs.issue_a_valid ? rs.issue_a_value : rs.cdb_value;
        entry_d[alloc_idx].a_tag   = rs.issue_a_rs_id;
        entry_d[alloc_idx].b_valid = rs.issue_b_valid || b_fwd;
        entry_d[alloc_idx].b_value = rs.issue_b_valid ? rs.issue_b_value : rs.cdb_value;
        entry_d[alloc_idx].b_tag   = rs.issue_b_rs_id;
        for (int j = 0; j < ENTRIES; j++) begin
          age_d[alloc_idx][j] = 1'b0;
          age_d[j][alloc_idx] = entry_q[j].busy;
        end
      end
    end
  end

  // NOTE: the entry storage is reset as a whole because reset must return every field to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      entry_q <= entry_d;
      age_q   <= age_d;
    end
  end
endmodule
